// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and constants for ram_arbiter (RR option: RAM_ARB_RR_EN)
package ram_arb_pkg;

   localparam int ADDR_W  = 30;
   localparam int BLOCK_W = 256;

   // Grant encodings, also used as the round-robin "last served" pointer.
   localparam logic OWN_IC = 1'b0;
   localparam logic OWN_DC = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } state_e;

endpackage

// File: rtl/ram_arb_pick.sv
// rtl/ram_arb_pick.sv - combinational winner selection (RR tie-break under RAM_ARB_RR_EN)
module ram_arb_pick
   import ram_arb_pkg::*;
(
   input  logic ic_req_i,
   input  logic dc_req_i,
   input  logic last_owner_i,
   output logic grant_o,
   output logic owner_o
);

`ifdef RAM_ARB_RR_EN
   // A tie goes to whichever side was not served last; a lone request always wins.
   always_comb begin
      grant_o = ic_req_i | dc_req_i;
      owner_o = OWN_DC;
      if (ic_req_i && !dc_req_i) begin
         owner_o = OWN_IC;
      end else if (ic_req_i && dc_req_i) begin
         owner_o = (last_owner_i == OWN_DC) ? OWN_IC : OWN_DC;
      end
   end
`else
   // Fixed priority: the D-cache wins every tie, so the pointer input is ignored.
   always_comb begin
      grant_o = ic_req_i | dc_req_i;
      owner_o = OWN_DC;
      if (ic_req_i && !dc_req_i) begin
         owner_o = OWN_IC;
      end
   end

   logic unused_last_owner;
   assign unused_last_owner = last_owner_i;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - I/D-cache arbiter in front of ddr_ctrl (RR option: RAM_ARB_RR_EN)
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int TIMEOUT_CYC = 4095
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               ic_req_i,
   input  logic [ADDR_W-1:0]  ic_addr_i,
   output logic               ic_done_o,
   output logic [BLOCK_W-1:0] ic_block_o,
   input  logic               dc_req_i,
   input  logic               dc_write_i,
   input  logic [ADDR_W-1:0]  dc_addr_i,
   input  logic [BLOCK_W-1:0] dc_wdata_i,
   output logic               dc_done_o,
   output logic [BLOCK_W-1:0] dc_block_o,
   output logic               ram_en_o,
   output logic               ram_write_o,
   output logic [ADDR_W-1:0]  ram_addr_o,
   output logic [BLOCK_W-1:0] ram_wdata_o,
   input  logic               ram_rdy_i,
   input  logic [BLOCK_W-1:0] ram_rdata_i,
   output logic               busy_o,
   output logic               owner_o,
   output logic               timeout_o
);

   localparam logic [11:0] TO_LIM = 12'(TIMEOUT_CYC);

   state_e               state_q, state_d;
   logic                 owner_q, owner_d;
   logic                 cmd_write_q, cmd_write_d;
   logic                 ram_en_q, ram_en_d;
   logic                 ram_write_q, ram_write_d;
   logic [ADDR_W-1:0]    ram_addr_q, ram_addr_d;
   logic [BLOCK_W-1:0]   ram_wdata_q, ram_wdata_d;
   logic [BLOCK_W-1:0]   ic_block_q, ic_block_d;
   logic [BLOCK_W-1:0]   dc_block_q, dc_block_d;
   logic                 ic_done_q, ic_done_d;
   logic                 dc_done_q, dc_done_d;
   logic                 busy_q, busy_d;
   logic                 timeout_q, timeout_d;
   logic [11:0]          cnt_q, cnt_d;
   logic                 last_owner;
   logic                 pick_grant;
   logic                 pick_owner;

   ram_arb_pick u_pick (
      .ic_req_i     (ic_req_i),
      .dc_req_i     (dc_req_i),
      .last_owner_i (last_owner),
      .grant_o      (pick_grant),
      .owner_o      (pick_owner)
   );

`ifdef RAM_ARB_RR_EN
   logic last_owner_q, last_owner_d;

   // Remember who was served last; cleared so the first tie favours the D-cache.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_owner_q <= OWN_IC;
      end else begin
         last_owner_q <= last_owner_d;
      end
   end

   // Pointer moves only when a transaction completes.
   always_comb begin
      last_owner_d = last_owner_q;
      if (state_q == ST_DONE) begin
         last_owner_d = owner_q;
      end
   end

   assign last_owner = last_owner_q;
`else
   assign last_owner = OWN_IC;
`endif

   // Next-state and next-output logic; every output is taken from a register.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      cmd_write_d = cmd_write_q;
      ram_en_d    = ram_en_q;
      ram_write_d = ram_write_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      ic_block_d  = ic_block_q;
      dc_block_d  = dc_block_q;
      ic_done_d   = 1'b0;
      dc_done_d   = 1'b0;
      timeout_d   = timeout_q;
      cnt_d       = cnt_q;

      unique case (state_q)
         ST_IDLE: begin
            // During a done pulse the finished requester still holds its req,
            // so arbitration waits one cycle for it to drop.
            if (pick_grant && !ic_done_q && !dc_done_q) begin
               owner_d = pick_owner;
               if (pick_owner == OWN_DC) begin
                  ram_addr_d  = dc_addr_i;
                  ram_wdata_d = dc_wdata_i;
                  cmd_write_d = dc_write_i;
               end else begin
                  ram_addr_d  = ic_addr_i;
                  ram_wdata_d = '0;
                  cmd_write_d = 1'b0;
               end
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            ram_en_d    = 1'b1;
            ram_write_d = cmd_write_q;
            cnt_d       = '0;
            state_d     = ST_WAIT;
         end
         ST_WAIT: begin
            if (ram_rdy_i) begin
               ram_en_d    = 1'b0;
               ram_write_d = 1'b0;
               if (owner_q == OWN_DC) begin
                  dc_block_d = ram_rdata_i;
               end else begin
                  ic_block_d = ram_rdata_i;
               end
               state_d = ST_DONE;
            end else begin
               // Timeout only flags the stall; the command stays outstanding.
               cnt_d = cnt_q + 12'd1;
               if (cnt_d == TO_LIM) begin
                  timeout_d = 1'b1;
               end
            end
         end
         ST_DONE: begin
            if (owner_q == OWN_DC) begin
               dc_done_d = 1'b1;
            end else begin
               ic_done_d = 1'b1;
            end
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; reset abandons any outstanding command.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         owner_q     <= OWN_IC;
         cmd_write_q <= 1'b0;
         ram_en_q    <= 1'b0;
         ram_write_q <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         ic_block_q  <= '0;
         dc_block_q  <= '0;
         ic_done_q   <= 1'b0;
         dc_done_q   <= 1'b0;
         busy_q      <= 1'b0;
         timeout_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         cmd_write_q <= cmd_write_d;
         ram_en_q    <= ram_en_d;
         ram_write_q <= ram_write_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         ic_block_q  <= ic_block_d;
         dc_block_q  <= dc_block_d;
         ic_done_q   <= ic_done_d;
         dc_done_q   <= dc_done_d;
         busy_q      <= busy_d;
         timeout_q   <= timeout_d;
         cnt_q       <= cnt_d;
      end
   end

   assign ic_done_o   = ic_done_q;
   assign ic_block_o  = ic_block_q;
   assign dc_done_o   = dc_done_q;
   assign dc_block_o  = dc_block_q;
   assign ram_en_o    = ram_en_q;
   assign ram_write_o = ram_write_q;
   assign ram_addr_o  = ram_addr_q;
   assign ram_wdata_o = ram_wdata_q;
   assign busy_o      = busy_q;
   assign owner_o     = owner_q;
   assign timeout_o   = timeout_q;

endmodule
